// File: rtl/sm83_nand_dyn.sv
// sm83_nand_dyn: bank of precharged (dynamic) NAND nodes sharing one
// precharge/evaluate pair. Models monotonic discharge, bounded charge
// retention with leakage, and a sticky per-channel leak flag.
//
// Control handshake: there is no backpressure. pch and eval are level
// requests sampled on each rising edge. pch wins over eval. y_valid
// qualifies y: it is high once at least one evaluation has happened
// since the last precharge.
module sm83_nand_dyn #(
  parameter int N_IN        = 2,
  parameter int CHANNELS    = 1,
  parameter int HOLD_CYCLES = 8,
  parameter int L_y         = 14
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pch,
  input  logic                       eval,
  input  logic [CHANNELS*N_IN-1:0]   in,
  output logic [CHANNELS-1:0]        y,
  output logic                       y_valid,
  output logic [CHANNELS-1:0]        leak,
  output logic [1:0]                 state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PRE  = 2'd1;
  localparam logic [1:0] ST_EVAL = 2'd2;

  // Age counter width: clog2(HOLD_CYCLES+1), never below one bit.
  localparam int AW = (HOLD_CYCLES > 0) ? (($clog2(HOLD_CYCLES + 1) > 0) ? $clog2(HOLD_CYCLES + 1) : 1) : 1;
  localparam logic [AW-1:0] AGE_MAX  = AW'(HOLD_CYCLES);
  localparam logic [AW-1:0] AGE_LAST = (HOLD_CYCLES > 0) ? AW'(HOLD_CYCLES - 1) : '0;

  // The output load only shapes analogue delays; it has no logical effect.
  logic unused_load;
  assign unused_load = ^L_y;

  logic [AW-1:0]       age;
  logic [CHANNELS-1:0] all_hi;
  logic [CHANNELS-1:0] y_eval;
  logic                live;
  logic                leak_edge;

  // Per-channel pull-down condition and the node value after evaluation.
  always_comb begin
    all_hi = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      all_hi[c] = &in[c*N_IN +: N_IN];
    end
    live      = (state != ST_IDLE);
    y_eval    = (eval && live) ? (y & ~all_hi) : y;
    // Leakage happens on the edge that moves age from HOLD-1 to HOLD.
    leak_edge = (HOLD_CYCLES != 0) && live && (age == AGE_LAST);
  end

  // Node, flag, age and FSM update with reset > pch > eval > leakage.
  always_ff @(posedge clk) begin
    if (reset) begin
      y       <= '1;
      y_valid <= 1'b0;
      leak    <= '0;
      age     <= '0;
      state   <= ST_IDLE;
    end else if (pch) begin
      y       <= '1;
      y_valid <= 1'b0;
      leak    <= '0;
      age     <= '0;
      state   <= ST_PRE;
    end else if (live) begin
      if (age != AGE_MAX) begin
        age <= age + AW'(1);
      end
      if (leak_edge) begin
        // Nodes discharged by evaluation this edge do not count as leaks.
        y    <= '0;
        leak <= leak | y_eval;
      end else begin
        y <= y_eval;
      end
      if (eval) begin
        y_valid <= 1'b1;
        state   <= ST_EVAL;
      end
    end
  end

endmodule
